// File: rtl/alu_pkg.sv
// ALU operation encoding shared by alu_client and the ALU it drives.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_client.sv
// alu_client: accepts tagged commands, issues them to an attached ALU through
// a one-deep registered request slot, remembers outstanding tags in order and
// returns each ALU response as a tagged completion from an in-order FIFO.
// A credit counter bounds commands in flight so that neither the tag queue
// nor the completion FIFO can overflow, which lets the ALU response path run
// without backpressure.
module alu_client #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  alu_pkg::alu_op_e       cmd_op,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [WIDTH-1:0]       req_a,
  output logic [WIDTH-1:0]       req_b,
  output alu_pkg::alu_op_e       req_op,
  input  logic                   rsp_valid,
  input  logic [WIDTH-1:0]       rsp_result,
  input  logic                   rsp_zero,
  input  logic                   rsp_neg,
  input  logic                   rsp_ovf,
  input  logic                   rsp_carry,
  output logic                   cpl_valid,
  input  logic                   cpl_ready,
  output logic [TAG_W-1:0]       cpl_tag,
  output logic [WIDTH-1:0]       cpl_result,
  output logic [3:0]             cpl_flags,
  output logic                   busy,
  output logic                   err_unexp_rsp
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

  // Request slot
  logic                 req_valid_q;
  logic [WIDTH-1:0]     req_a_q;
  logic [WIDTH-1:0]     req_b_q;
  alu_pkg::alu_op_e     req_op_q;
  logic [TAG_W-1:0]     req_tag_q;

  // Credits and status
  logic [CW-1:0]        credit_q, credit_d;
  logic                 busy_q;
  logic                 err_q;

  // In-order tag queue for requests already handed to the ALU
  logic [TAG_W-1:0]     tq_mem_q [DEPTH];
  logic [AW-1:0]        tq_wr_q, tq_rd_q;
  logic [CW-1:0]        tq_cnt_q, tq_cnt_d;

  // Completion FIFO
  logic [TAG_W-1:0]     cf_tag_q [DEPTH];
  logic [WIDTH-1:0]     cf_res_q [DEPTH];
  logic [3:0]           cf_flg_q [DEPTH];
  logic [AW-1:0]        cf_wr_q, cf_rd_q;
  logic [CW-1:0]        cf_cnt_q, cf_cnt_d;
  logic                 cpl_valid_q;

  // Handshake qualifiers
  logic cmd_ready_s;
  logic cmd_hs_s;
  logic req_hs_s;
  logic tq_pop_s;
  logic stray_s;
  logic cpl_hs_s;

  // Reset is folded into cmd_ready so nothing is accepted while held in reset.
  assign cmd_ready_s = rst_n && (!req_valid_q || req_ready) && (credit_q < CNT_MAX);
  assign cmd_hs_s    = cmd_valid && cmd_ready_s;
  assign req_hs_s    = req_valid_q && req_ready;
  assign tq_pop_s    = rsp_valid && (tq_cnt_q != CNT_ZERO);
  assign stray_s     = rsp_valid && (tq_cnt_q == CNT_ZERO);
  assign cpl_hs_s    = cpl_valid_q && cpl_ready;

  // Next-state occupancy for credits, tag queue and completion FIFO.
  always_comb begin
    credit_d = credit_q;
    tq_cnt_d = tq_cnt_q;
    cf_cnt_d = cf_cnt_q;
    case ({cmd_hs_s, cpl_hs_s})
      2'b10:   credit_d = credit_q + CNT_ONE;
      2'b01:   credit_d = credit_q - CNT_ONE;
      default: credit_d = credit_q;
    endcase
    case ({req_hs_s, tq_pop_s})
      2'b10:   tq_cnt_d = tq_cnt_q + CNT_ONE;
      2'b01:   tq_cnt_d = tq_cnt_q - CNT_ONE;
      default: tq_cnt_d = tq_cnt_q;
    endcase
    case ({tq_pop_s, cpl_hs_s})
      2'b10:   cf_cnt_d = cf_cnt_q + CNT_ONE;
      2'b01:   cf_cnt_d = cf_cnt_q - CNT_ONE;
      default: cf_cnt_d = cf_cnt_q;
    endcase
  end

  // Control state: request slot, pointers, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_a_q     <= {WIDTH{1'b0}};
      req_b_q     <= {WIDTH{1'b0}};
      req_op_q    <= alu_pkg::ALU_ADD;
      req_tag_q   <= {TAG_W{1'b0}};
      credit_q    <= CNT_ZERO;
      tq_wr_q     <= {AW{1'b0}};
      tq_rd_q     <= {AW{1'b0}};
      tq_cnt_q    <= CNT_ZERO;
      cf_wr_q     <= {AW{1'b0}};
      cf_rd_q     <= {AW{1'b0}};
      cf_cnt_q    <= CNT_ZERO;
      cpl_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // A new command reloads the slot even in the cycle its previous
      // occupant is taken by the ALU, giving back-to-back issue.
      if (cmd_hs_s) begin
        req_valid_q <= 1'b1;
        req_a_q     <= cmd_a;
        req_b_q     <= cmd_b;
        req_op_q    <= cmd_op;
        req_tag_q   <= cmd_tag;
      end else if (req_hs_s) begin
        req_valid_q <= 1'b0;
      end
      if (req_hs_s) begin
        tq_wr_q <= tq_wr_q + PTR_ONE;
      end
      if (tq_pop_s) begin
        tq_rd_q <= tq_rd_q + PTR_ONE;
        cf_wr_q <= cf_wr_q + PTR_ONE;
      end
      if (cpl_hs_s) begin
        cf_rd_q <= cf_rd_q + PTR_ONE;
      end
      if (stray_s) begin
        err_q <= 1'b1;
      end
      credit_q    <= credit_d;
      tq_cnt_q    <= tq_cnt_d;
      cf_cnt_q    <= cf_cnt_d;
      cpl_valid_q <= (cf_cnt_d != CNT_ZERO);
      busy_q      <= (credit_d != CNT_ZERO);
    end
  end

  // Storage for pending tags and buffered completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tq_mem_q[i] <= {TAG_W{1'b0}};
        cf_tag_q[i] <= {TAG_W{1'b0}};
        cf_res_q[i] <= {WIDTH{1'b0}};
        cf_flg_q[i] <= 4'b0000;
      end
    end else begin
      if (req_hs_s) begin
        tq_mem_q[tq_wr_q] <= req_tag_q;
      end
      if (tq_pop_s) begin
        cf_tag_q[cf_wr_q] <= tq_mem_q[tq_rd_q];
        cf_res_q[cf_wr_q] <= rsp_result;
        cf_flg_q[cf_wr_q] <= {rsp_zero, rsp_neg, rsp_ovf, rsp_carry};
      end
    end
  end

  assign cmd_ready     = cmd_ready_s;
  assign req_valid     = req_valid_q;
  assign req_a         = req_a_q;
  assign req_b         = req_b_q;
  assign req_op        = req_op_q;
  assign cpl_valid     = cpl_valid_q;
  assign cpl_tag       = cf_tag_q[cf_rd_q];
  assign cpl_result    = cf_res_q[cf_rd_q];
  assign cpl_flags     = cf_flg_q[cf_rd_q];
  assign busy          = busy_q;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_alu_client.sv
// Testbench for alu_client: a two-stage pipelined ALU model answers requests,
// a monitor records accepted commands and delivered completions, and each
// scenario task compares the completions against a reference ALU function.
module tb_alu_client;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  alu_op_e     cmd_op;
  logic [3:0]  cmd_tag;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  alu_op_e     req_op;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_neg, rsp_ovf, rsp_carry;
  logic        cpl_valid, cpl_ready;
  logic [3:0]  cpl_tag;
  logic [31:0] cpl_result;
  logic [3:0]  cpl_flags;
  logic        busy, err_unexp_rsp;

  int n_checks = 0;
  int n_errors = 0;
  int tag_ctr  = 0;
  int cplv_cnt = 0;
  logic stray = 1'b0;

  typedef struct packed {logic [3:0] tag; logic [31:0] a; logic [31:0] b; alu_op_e op;} cmd_t;
  typedef struct packed {logic [3:0] tag; logic [31:0] res; logic [3:0] flg;} cpl_t;
  cmd_t acc_q[$];
  cpl_t got_q[$];

  alu_client #(.WIDTH(32), .DEPTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .rsp_ovf(rsp_ovf), .rsp_carry(rsp_carry),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_result(cpl_result),
    .cpl_flags(cpl_flags), .busy(busy), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {zero,neg,ovf,carry,result}.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input alu_op_e op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r[31], v, c, r};
  endfunction

  // ALU model: two-stage pipeline, response two edges after the request handshake.
  logic        p1_v, p2_v;
  logic [35:0] p1_d, p2_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= 36'd0; p2_d <= 36'd0;
    end else begin
      p1_v <= req_valid && req_ready;
      p1_d <= ref_alu(req_a, req_b, req_op);
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end
  assign rsp_valid  = p2_v | stray;
  assign rsp_result = p2_d[31:0];
  assign {rsp_zero, rsp_neg, rsp_ovf, rsp_carry} = p2_d[35:32];

  // Monitor: record accepted commands and delivered completions.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cmd_t'({cmd_tag, cmd_a, cmd_b, cmd_op}));
      if (cpl_valid && cpl_ready) got_q.push_back(cpl_t'({cpl_tag, cpl_result, cpl_flags}));
      if (cpl_valid) cplv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Offer up to n commands within a cycle budget; rnd also randomizes ready inputs.
  task automatic drive_cmds(input int n, input int budget, input bit rnd, output int cycles);
    int idx;
    bit hs;
    idx = 0;
    cycles = 0;
    while (idx < n && cycles < budget) begin
      if (rnd) begin
        req_ready = ($urandom_range(0, 3) != 0);
        cpl_ready = ($urandom_range(0, 2) != 0);
      end
      if (!rnd || $urandom_range(0, 3) != 0) begin
        cmd_valid = 1'b1;
        cmd_a = rand_operand();
        cmd_b = rand_operand();
        cmd_op = alu_op_e'(3'($urandom_range(0, 7)));
        cmd_tag = 4'(tag_ctr);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      hs = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (hs) begin
        idx++;
        tag_ctr++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // Let everything outstanding complete; ok=0 if it does not within the budget.
  task automatic wait_idle(output bit ok);
    int n;
    req_ready = 1'b1;
    cpl_ready = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    ok = !busy;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_op = ALU_ADD; cmd_tag = 4'd0;
    req_ready = 1'b0; cpl_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({cmd_ready, req_valid, cpl_valid, busy, err_unexp_rsp} !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_ctrl: cmd_ready,req_valid,cpl_valid,busy,err = %b, expected 00000",
               {cmd_ready, req_valid, cpl_valid, busy, err_unexp_rsp});
    end
    n_checks++;
    if (req_a !== 32'd0 || req_b !== 32'd0 || req_op !== ALU_ADD) begin
      n_errors++;
      $display("FAIL reset_req: a=%h b=%h op=%0d, expected 0 0 ADD", req_a, req_b, req_op);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: cmd_ready=%b, expected 1", cmd_ready);
    end
    tick();
  endtask

  task automatic test_single();
    acc_q.delete(); got_q.delete();
    req_ready = 1'b1; cpl_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 32'd5; cmd_b = 32'd3; cmd_op = ALU_SUB; cmd_tag = 4'd2;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL single_ready: cmd_ready=%b, expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || req_a !== 32'd5 || req_b !== 32'd3 || req_op !== ALU_SUB) begin
      n_errors++;
      $display("FAIL single_req: v=%b a=%h b=%h op=%0d, expected 1 5 3 SUB", req_valid, req_a, req_b, req_op);
    end
    tick();
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_req_drop: req_valid=%b, expected 0", req_valid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || cpl_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_k2: rsp_valid=%b cpl_valid=%b, expected 1 0", rsp_valid, cpl_valid);
    end
    tick();
    n_checks++;
    if (cpl_valid !== 1'b1 || cpl_tag !== 4'd2 || cpl_result !== 32'd2 || cpl_flags !== 4'b0001) begin
      n_errors++;
      $display("FAIL single_cpl: v=%b tag=%0d res=%h flags=%b, expected 1 2 2 0001",
               cpl_valid, cpl_tag, cpl_result, cpl_flags);
    end
    tick();
    n_checks++;
    if (cpl_valid !== 1'b0 || busy !== 1'b0 || got_q.size() != 1) begin
      n_errors++;
      $display("FAIL single_done: cpl_valid=%b busy=%b completions=%0d, expected 0 0 1",
               cpl_valid, busy, got_q.size());
    end
  endtask

  task automatic test_flags();
    logic [31:0] ta[3], tb[3], tr[3];
    logic [3:0]  tf[3];
    alu_op_e     to[3];
    bit ok;
    ta[0] = 32'h7FFF_FFFF; tb[0] = 32'd1; to[0] = ALU_ADD; tr[0] = 32'h8000_0000; tf[0] = 4'b0110;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd1; to[1] = ALU_ADD; tr[1] = 32'h0000_0000; tf[1] = 4'b1001;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'd1; to[2] = ALU_SLT; tr[2] = 32'h0000_0001; tf[2] = 4'b0000;
    acc_q.delete(); got_q.delete();
    req_ready = 1'b1; cpl_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = ta[i]; cmd_b = tb[i]; cmd_op = to[i]; cmd_tag = 4'(i + 5);
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok || got_q.size() != 3) begin
      n_errors++; $display("FAIL flags_count: idle=%b completions=%0d, expected 1 3", ok, got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].tag !== 4'(i + 5) || got_q[i].res !== tr[i] || (i < 2 && got_q[i].flg !== tf[i])) begin
        n_errors++;
        $display("FAIL flags_%0d: tag=%0d res=%h flags=%b, expected %0d %h %b",
                 i, got_q[i].tag, got_q[i].res, got_q[i].flg, i + 5, tr[i], tf[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [35:0] e;
    acc_q.delete(); got_q.delete();
    req_ready = 1'b0; cpl_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 32'h1234_5678; cmd_b = 32'h0F0F_0F0F; cmd_op = ALU_XOR; cmd_tag = 4'd9;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_a !== 32'h1234_5678 || req_b !== 32'h0F0F_0F0F ||
          req_op !== ALU_XOR || cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: v=%b a=%h b=%h op=%0d cmd_ready=%b, expected 1 12345678 0f0f0f0f XOR 0",
                 i, req_valid, req_a, req_b, req_op, cmd_ready);
      end
      tick();
    end
    req_ready = 1'b1;
    repeat (10) tick();
    e = ref_alu(32'h1234_5678, 32'h0F0F_0F0F, ALU_XOR);
    n_checks++;
    if (got_q.size() != 1 || req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_count: completions=%0d req_valid=%b, expected 1 0", got_q.size(), req_valid);
    end else if (got_q[0] !== cpl_t'({4'd9, e[31:0], e[35:32]})) begin
      n_errors++;
      $display("FAIL stall_cpl: got %h, expected %h", got_q[0], cpl_t'({4'd9, e[31:0], e[35:32]}));
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    logic [35:0] e;
    acc_q.delete(); got_q.delete();
    req_ready = 1'b1; cpl_ready = 1'b0;
    drive_cmds(10, 20, 1'b0, cyc);
    n_checks++;
    if (acc_q.size() != 8 || cmd_ready !== 1'b0 || busy !== 1'b1 || cpl_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: accepted=%0d cmd_ready=%b busy=%b cpl_valid=%b, expected 8 0 1 1",
               acc_q.size(), cmd_ready, busy, cpl_valid);
    end
    cpl_ready = 1'b1;
    drive_cmds(2, 40, 1'b0, cyc);
    wait_idle(ok);
    n_checks++;
    if (!ok || acc_q.size() != 10 || got_q.size() != 10) begin
      n_errors++;
      $display("FAIL bp_count: idle=%b accepted=%0d completions=%0d, expected 1 10 10",
               ok, acc_q.size(), got_q.size());
    end
    for (int i = 0; i < acc_q.size() && i < got_q.size(); i++) begin
      e = ref_alu(acc_q[i].a, acc_q[i].b, acc_q[i].op);
      n_checks++;
      if (got_q[i] !== cpl_t'({acc_q[i].tag, e[31:0], e[35:32]})) begin
        n_errors++;
        $display("FAIL bp_cpl_%0d: got %h, expected %h", i, got_q[i], cpl_t'({acc_q[i].tag, e[31:0], e[35:32]}));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    logic [35:0] e;
    acc_q.delete(); got_q.delete();
    req_ready = 1'b1; cpl_ready = 1'b1;
    drive_cmds(20, 20, 1'b0, cyc);
    n_checks++;
    if (acc_q.size() != 20) begin
      n_errors++; $display("FAIL b2b_rate: accepted %0d in 20 cycles, expected 20", acc_q.size());
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || got_q.size() != acc_q.size()) begin
      n_errors++;
      $display("FAIL b2b_count: idle=%b completions=%0d, expected 1 %0d", ok, got_q.size(), acc_q.size());
    end
    for (int i = 0; i < acc_q.size() && i < got_q.size(); i++) begin
      e = ref_alu(acc_q[i].a, acc_q[i].b, acc_q[i].op);
      n_checks++;
      if (got_q[i] !== cpl_t'({acc_q[i].tag, e[31:0], e[35:32]})) begin
        n_errors++;
        $display("FAIL b2b_cpl_%0d: got %h, expected %h", i, got_q[i], cpl_t'({acc_q[i].tag, e[31:0], e[35:32]}));
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    bit ok;
    logic [35:0] e;
    acc_q.delete(); got_q.delete();
    drive_cmds(150, 3000, 1'b1, cyc);
    wait_idle(ok);
    n_checks++;
    if (!ok || acc_q.size() != 150 || got_q.size() != 150) begin
      n_errors++;
      $display("FAIL rand_count: idle=%b accepted=%0d completions=%0d, expected 1 150 150",
               ok, acc_q.size(), got_q.size());
    end
    for (int i = 0; i < acc_q.size() && i < got_q.size(); i++) begin
      e = ref_alu(acc_q[i].a, acc_q[i].b, acc_q[i].op);
      n_checks++;
      if (got_q[i] !== cpl_t'({acc_q[i].tag, e[31:0], e[35:32]})) begin
        n_errors++;
        $display("FAIL rand_cpl_%0d: got %h, expected %h", i, got_q[i], cpl_t'({acc_q[i].tag, e[31:0], e[35:32]}));
      end
    end
  endtask

  task automatic test_stray();
    got_q.delete();
    cplv_cnt = 0;
    n_checks++;
    if (err_unexp_rsp !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL stray_pre: err=%b busy=%b, expected 0 0", err_unexp_rsp, busy);
    end
    stray = 1'b1;
    tick();
    stray = 1'b0;
    n_checks++;
    if (err_unexp_rsp !== 1'b1) begin
      n_errors++; $display("FAIL stray_set: err=%b, expected 1", err_unexp_rsp);
    end
    repeat (6) tick();
    n_checks++;
    if (err_unexp_rsp !== 1'b1 || cplv_cnt != 0 || got_q.size() != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_sticky: err=%b cpl_valid_cycles=%0d completions=%0d busy=%b, expected 1 0 0 0",
               err_unexp_rsp, cplv_cnt, got_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    acc_q.delete(); got_q.delete();
    req_ready = 1'b1; cpl_ready = 1'b0;
    drive_cmds(3, 10, 1'b0, cyc);
    tick();
    n_checks++;
    if (busy !== 1'b1 || acc_q.size() != 3) begin
      n_errors++; $display("FAIL rmid_pre: busy=%b accepted=%0d, expected 1 3", busy, acc_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, req_valid, cpl_valid, busy, err_unexp_rsp} !== 5'b00000 ||
        req_a !== 32'd0 || req_b !== 32'd0 || req_op !== ALU_ADD) begin
      n_errors++;
      $display("FAIL rmid_reset: ctrl=%b a=%h b=%h op=%0d, expected 00000 0 0 ADD",
               {cmd_ready, req_valid, cpl_valid, busy, err_unexp_rsp}, req_a, req_b, req_op);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL rmid_release: cmd_ready=%b, expected 1", cmd_ready);
    end
    got_q.delete();
    cplv_cnt = 0;
    cpl_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (got_q.size() != 0 || cplv_cnt != 0 || busy !== 1'b0 || req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_after: completions=%0d cpl_valid_cycles=%0d busy=%b req_valid=%b, expected 0 0 0 0",
               got_q.size(), cplv_cnt, busy, req_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_stray();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_client.md
ALU_CLIENT -- requirements
Module: alu_client

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 32, operand/result width; must match the attached alu.
- DEPTH, 8, completion buffer/tag queue entries; power of two, >=2.
- TAG_W, 4, command tag width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_a, cmd_b  in  WIDTH  operands.
- cmd_op  in  alu_pkg::alu_op_e  operation.
- cmd_tag  in  TAG_W  user tag returned with completion.
- req_valid  out  1  request to alu.
- req_ready  in  1  alu accept.
- req_a, req_b  out  WIDTH  request operands.
- req_op  out  alu_pkg::alu_op_e  request operation.
- rsp_valid  in  1  alu response strobe; no backpressure.
- rsp_result  in  WIDTH  alu result.
- rsp_zero, rsp_neg, rsp_ovf, rsp_carry  in  1 each  alu flags.
- cpl_valid  out  1  completion available.
- cpl_ready  in  1  completion consumed when both high.
- cpl_tag  out  TAG_W  tag of the completed command.
- cpl_result  out  WIDTH  result.
- cpl_flags  out  4  {zero,neg,ovf,carry}.
- busy  out  1  credit_cnt!=0.
- err_unexp_rsp  out  1  sticky: rsp_valid with empty tag queue.

Function
REQ-003 Block SHALL hold one registered request slot (req_valid, req_a, req_b, req_op, tag); all req_* outputs are flop outputs.
REQ-004 cmd_ready SHALL be (!req_valid || req_ready) && (credit_cnt < DEPTH), with no dependency on cmd_valid or cpl_ready.
REQ-005 On cmd handshake the request slot SHALL load and req_valid is 1 the next cycle.
REQ-006 While req_valid && !req_ready, req_* and the slot tag SHALL hold stable.
REQ-007 On req handshake without a new cmd, req_valid SHALL drop to 0 next cycle; with a new cmd, back-to-back issue SHALL occur.
REQ-008 On req handshake, the slot tag SHALL be pushed to an in-order tag queue of DEPTH entries.
REQ-009 credit_cnt (0..DEPTH) SHALL increment on cmd handshake, decrement on cpl handshake, and hold when both or neither occur.
REQ-010 Credits SHALL guarantee that tag queue and completion buffer never overflow; rsp_valid is never dropped when a tag is pending.
REQ-011 On rsp_valid with a non-empty tag queue, the block SHALL pop the tag and write {tag, rsp_result, flags} into the completion FIFO (DEPTH entries).
REQ-012 On rsp_valid with an empty tag queue, the response SHALL be discarded and err_unexp_rsp set to 1 until reset.
REQ-013 cpl_valid SHALL equal completion FIFO non-empty, asserting the cycle after the rsp_valid write (no fall-through); cpl_* SHALL be stable while cpl_valid && !cpl_ready.
REQ-014 Completions SHALL leave in command-acceptance order, with tag, result and flags bit-exact to the alu response.
REQ-015 Simultaneous completion-FIFO write and read SHALL both take effect, including when the FIFO holds 1 entry or is full (DEPTH entries); pointers wrap modulo DEPTH.
REQ-016 Latency: cmd handshake at edge k; req_valid=1 after k; with req_ready=1, rsp_valid after k+2, cpl_valid after k+3.
REQ-017 With req_ready=1, cpl_ready=1 and DEPTH>=5, sustained throughput SHALL be one command per cycle.

Reset
REQ-018 On rst_n=0, the block SHALL asynchronously clear the following: req_valid=0, req_a=req_b=0, req_op=ALU_ADD, credit_cnt=0, tag queue and FIFO empty, cpl_valid=0, busy=0, err_unexp_rsp=0.
REQ-019 While in reset, cmd_ready SHALL be 0.
REQ-020 Reset mid-operation SHALL discard all in-flight commands and completions without generating any completion after release.
REQ-021 After reset release, cmd_ready SHALL be 1 on the first clk edge.

Verification
REQ-022 Single op: a=5, b=3, ALU_SUB, tag=2 -> one completion: tag=2, result=2, flags=0001, 3 cycles after cpl-FIFO write path.
REQ-023 Backpressure: cpl_ready=0, issue 10 commands -> exactly DEPTH=8 accepted; cmd_ready=0 thereafter; busy=1; then cpl_ready=1 -> 8 in-order completions, then remaining 2 accepted.
REQ-024 Stall: req_ready=0 for 5 cycles with req_valid=1 -> req_a/req_b/req_op unchanged across stall; exactly one response per request.
REQ-025 Flags: ADD 0x7FFFFFFF+1 -> result=0x80000000, flags=0110; ADD 0xFFFFFFFF+1 -> result=0, flags=1001; SLT -1,1 -> result=1.
REQ-026 Stray rsp_valid pulse with nothing outstanding -> err_unexp_rsp=1 and stays 1, no cpl_valid.
REQ-027 Reset with 3 outstanding -> all outputs at reset values; no completion after release.
